// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared constants for the instruction-fetch front end
package if_fetch_pkg;

    localparam int                     MEM_ADDR_W   = 32;
    localparam int                     INST_W       = 32;
    localparam logic [INST_W-1:0]      INST_NOP     = 32'h0000_0013;
    localparam logic [MEM_ADDR_W-1:0]  RESET_PC_DEF = 32'h0000_0000;

    // PC step between sequential fetches (one 32-bit word)
    localparam int                     PC_STEP      = 4;

endpackage

// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - synchronous FIFO with flush, used for the pc queue and instruction buffer
module if_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    always_comb begin
        full_o   = (cnt_q == CW'(DEPTH));
        empty_o  = (cnt_q == '0);
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read while count says they are live.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction-fetch front end: PC, credit-limited requests, response buffer, redirect
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int                ADDR_W   = MEM_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter int                DEPTH    = 2
) (
    input  logic              clk_100MHz,
    input  logic              rst,
    input  logic              hold_i,
    input  logic              jump_ena_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [INST_W-1:0] imem_rdata_i,
    output logic              if_valid_o,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [INST_W-1:0] if_inst_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = CW + 2;
    localparam int BW = ADDR_W + INST_W;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CW-1:0]     outst_q, outst_d;
    logic [CW-1:0]     disc_q, disc_d;
    logic [IW-1:0]     in_use;
    logic              req, issue, accept, drop, pop;

    logic [ADDR_W-1:0] pcq_head;
    logic [CW-1:0]     pcq_count;
    logic              pcq_full, pcq_empty;
    logic [BW-1:0]     buf_head;
    logic [CW-1:0]     buf_count;
    logic              buf_full, buf_empty, buf_valid;

    assign buf_valid = !buf_empty;

    always_comb begin
        // Credits cover everything not yet consumed, including responses still to be dropped,
        // so an accepted response always finds room in the buffer.
        in_use  = IW'(outst_q) + IW'(disc_q) + IW'(buf_count);
        req     = !rst && !jump_ena_i && (in_use < IW'(DEPTH));
        issue   = req && imem_gnt_i;
        drop    = imem_rvalid_i && (disc_q != '0);
        accept  = imem_rvalid_i && (disc_q == '0) && (outst_q != '0);
        pop     = buf_valid && !hold_i && !jump_ena_i;
        pc_d    = pc_q;
        outst_d = outst_q;
        disc_d  = disc_q;
        if (jump_ena_i) begin
            pc_d    = jump_addr_i & ~ADDR_W'(3);
            outst_d = '0;
            disc_d  = disc_q + outst_q - CW'(drop || accept);
        end else begin
            if (issue) begin
                pc_d = pc_q + ADDR_W'(PC_STEP);
            end
            outst_d = outst_q + CW'(issue) - CW'(accept);
            if (drop) begin
                disc_d = disc_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            outst_q <= '0;
            disc_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            outst_q <= outst_d;
            disc_q  <= disc_d;
        end
    end

    if_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_pc_queue (
        .clk_i   (clk_100MHz),
        .rst_i   (rst),
        .flush_i (jump_ena_i),
        .push_i  (issue),
        .wdata_i (pc_q),
        .pop_i   (accept),
        .rdata_o (pcq_head),
        .count_o (pcq_count),
        .full_o  (pcq_full),
        .empty_o (pcq_empty)
    );

    if_fifo #(
        .WIDTH (BW),
        .DEPTH (DEPTH)
    ) u_inst_buf (
        .clk_i   (clk_100MHz),
        .rst_i   (rst),
        .flush_i (jump_ena_i),
        .push_i  (accept),
        .wdata_i ({pcq_head, imem_rdata_i}),
        .pop_i   (pop),
        .rdata_o (buf_head),
        .count_o (buf_count),
        .full_o  (buf_full),
        .empty_o (buf_empty)
    );

    assign imem_req_o  = req;
    assign imem_addr_o = pc_q;
    assign if_valid_o  = !rst && buf_valid;
    assign if_pc_o     = if_valid_o ? buf_head[BW-1:INST_W] : '0;
    assign if_inst_o   = if_valid_o ? buf_head[INST_W-1:0] : INST_NOP;

    always @(posedge clk_100MHz) begin
        if (!rst) begin
            assert (outst_q <= CW'(DEPTH));
            assert (disc_q <= CW'(DEPTH));
            assert (pcq_count == outst_q);
            assert (!(issue && pcq_full));
            assert (!(accept && pcq_empty));
            assert (!(accept && !jump_ena_i && buf_full && !pop));
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - randomized self-checking bench for if_fetch against a queue-based model
module tb_if_fetch;

    localparam int          ADDR_W = 32;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk_100MHz = 1'b0;
    logic        rst = 1'b1;
    logic        hold_i = 1'b0;
    logic        jump_ena_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;

    always #5 clk_100MHz = ~clk_100MHz;

    if_fetch #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (32'h0000_0000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk_100MHz    (clk_100MHz),
        .rst           (rst),
        .hold_i        (hold_i),
        .jump_ena_i    (jump_ena_i),
        .jump_addr_i   (jump_addr_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .if_valid_o    (if_valid_o),
        .if_pc_o       (if_pc_o),
        .if_inst_o     (if_inst_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic        stale;
        int          ready;
    } rsp_t;

    rsp_t        memq[$];
    logic [31:0] bufq[$];
    logic [31:0] exp_pc;
    int          cyc;
    int          lat_max;
    int          last_ready;
    int          checks;
    int          errors;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input logic h, input logic j, input logic [31:0] ja, input logic g);
        logic exp_req;
        logic rv;
        logic do_pop;
        rsp_t head;
        int   r;
        @(posedge clk_100MHz);
        #1;
        cyc++;
        rst         = 1'b0;
        hold_i      = h;
        jump_ena_i  = j;
        jump_addr_i = ja;
        imem_gnt_i  = g;
        rv = (memq.size() != 0) && (memq[0].ready <= cyc);
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? mem_word(memq[0].addr) : 32'($urandom);
        #3;
        exp_req = !j && (memq.size() + bufq.size() < DEPTH);
        check("req", imem_req_o, exp_req);
        if (exp_req) check("addr", imem_addr_o, exp_pc);
        check("valid", if_valid_o, bufq.size() != 0);
        if (bufq.size() != 0) begin
            check("pc", if_pc_o, bufq[0]);
            check("inst", if_inst_o, mem_word(bufq[0]));
        end else begin
            check("nop", if_inst_o, NOP);
        end
        do_pop = (bufq.size() != 0) && !h && !j;
        if (do_pop) void'(bufq.pop_front());
        if (rv) begin
            head = memq.pop_front();
            if (!head.stale && !j) bufq.push_back(head.addr);
        end
        if (j) begin
            foreach (memq[i]) memq[i].stale = 1'b1;
            bufq.delete();
            exp_pc = {ja[31:2], 2'b00};
        end else if (exp_req && g) begin
            r = cyc + 1 + int'($urandom_range(0, lat_max));
            if (r < last_ready) r = last_ready;
            last_ready = r;
            memq.push_back('{exp_pc, 1'b0, r});
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk_100MHz);
        #1;
        rst           = 1'b1;
        hold_i        = 1'b0;
        jump_ena_i    = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i != 0) begin
                @(posedge clk_100MHz);
                #1;
            end
            #3;
            check("rst_req", imem_req_o, 1'b0);
            check("rst_valid", if_valid_o, 1'b0);
            check("rst_inst", if_inst_o, NOP);
            check("rst_pc", if_pc_o, 32'h0);
        end
        memq.delete();
        bufq.delete();
        exp_pc     = 32'h0;
        last_ready = 0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        lat_max    = 0;
        last_ready = 0;
        exp_pc     = 32'h0;
        do_reset(3);

        // streaming with one-cycle memory latency
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // hold freezes the output, requests stop once credits run out
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // redirect with two fetches in flight
        lat_max = 3;
        for (int i = 0; i < 20 && memq.size() < 2; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0103, 1'b1);
        lat_max = 0;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // jump coinciding with gnt, then a second jump
        lat_max = 1;
        step(1'b0, 1'b1, 32'h0000_0200, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0300, 1'b1);
        step(1'b0, 1'b1, 32'h0000_0402, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // PC wrap
        lat_max = 0;
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // reset with a full buffer under hold
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
        do_reset(2);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] ja;
            if (i % 50 == 0) lat_max = int'($urandom_range(0, 3));
            ja = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16)) : 32'($urandom);
            step(($urandom % 10) < 3, ($urandom % 20) == 0, ja, ($urandom % 10) < 7);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
